// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the counter sequencer: FSM states, register map,
// CMD/CTRL bit positions and prescaler divide terminals.
package counter_seq_pkg;

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned TERM_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [ADDR_W-1:0] ADDR_LOAD  = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = 2'd1;
  localparam logic [ADDR_W-1:0] ADDR_CTRL  = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_CMD   = 2'd3;

  localparam int unsigned CMD_START_BIT = 0;
  localparam int unsigned CMD_STOP_BIT  = 1;
  localparam int unsigned CMD_CLEAR_BIT = 2;

  localparam int unsigned CTRL_DIR_BIT  = 0;
  localparam int unsigned CTRL_AUTO_BIT = 1;
  localparam int unsigned CTRL_PSC_LSB  = 2;

  typedef enum logic [1:0] {
    PSC_DIV1   = 2'd0,
    PSC_DIV4   = 2'd1,
    PSC_DIV16  = 2'd2,
    PSC_DIV256 = 2'd3
  } psc_sel_e;

  localparam logic [TERM_W-1:0] PSC_TERM_DIV1   = 8'd0;
  localparam logic [TERM_W-1:0] PSC_TERM_DIV4   = 8'd3;
  localparam logic [TERM_W-1:0] PSC_TERM_DIV16  = 8'd15;
  localparam logic [TERM_W-1:0] PSC_TERM_DIV256 = 8'd255;

  // CTRL register layout, MSB first, matching the D nibble.
  typedef struct packed {
    logic [1:0] psc_sel;
    logic       auto_reload;
    logic       dir;
  } ctrl_t;

  function automatic logic [TERM_W-1:0] psc_term(input logic [1:0] sel);
    logic [TERM_W-1:0] term;
    case (psc_sel_e'(sel))
      PSC_DIV1:  term = PSC_TERM_DIV1;
      PSC_DIV4:  term = PSC_TERM_DIV4;
      PSC_DIV16: term = PSC_TERM_DIV16;
      default:   term = PSC_TERM_DIV256;
    endcase
    return term;
  endfunction

endpackage

// File: rtl/counter_core.sv
// 4-bit loadable up/down counter; load has priority over enable, wraps modulo 16.
module counter_core
  import counter_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic             dir_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i) begin
      count_d = dir_i ? (count_q - CNT_W'(1)) : (count_q + CNT_W'(1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tt_um_counter_sequencer.sv
// Tiny Tapeout top: strobed nibble register interface, prescaler and sequencing FSM
// wrapped around counter_core.
module tt_um_counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int unsigned PRESCALE_W = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic                  wr_sync1_q, wr_sync2_q, wr_prev_q;
  logic [CNT_W-1:0]      load_q;
  logic [CNT_W-1:0]      limit_q;
  ctrl_t                 ctrl_q;
  logic [PRESCALE_W-1:0] presc_q;
  state_e                state_q;
  logic                  tc_q;

  logic                  wr_pulse;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data;
  logic                  cmd_wr, clear_cmd, stop_cmd, start_cmd;
  logic [PRESCALE_W-1:0] presc_term;
  logic                  presc_hit, tick, match;
  logic                  cnt_load, cnt_en;
  logic [CNT_W-1:0]      count;

  wire unused_inputs = &{1'b0, ena, ui_in[5:4], uio_in[7:1]};

  assign addr = ui_in[7:6];
  assign data = ui_in[3:0];

  // WR is asynchronous to clk: two-flop synchronizer, then rising-edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_sync1_q <= 1'b0;
      wr_sync2_q <= 1'b0;
      wr_prev_q  <= 1'b0;
    end else begin
      wr_sync1_q <= uio_in[0];
      wr_sync2_q <= wr_sync1_q;
      wr_prev_q  <= wr_sync2_q;
    end
  end

  assign wr_pulse = wr_sync2_q & ~wr_prev_q;

  // Command decode with CLEAR > STOP > START; any CMD write swallows a coincident tick.
  always_comb begin
    cmd_wr     = wr_pulse && (addr == ADDR_CMD);
    clear_cmd  = cmd_wr && data[CMD_CLEAR_BIT];
    stop_cmd   = cmd_wr && !data[CMD_CLEAR_BIT] && data[CMD_STOP_BIT];
    start_cmd  = cmd_wr && !data[CMD_CLEAR_BIT] && !data[CMD_STOP_BIT] && data[CMD_START_BIT];
    presc_term = PRESCALE_W'(psc_term(ctrl_q.psc_sel));
    // >= keeps a lowered divide from waiting a full prescaler wrap.
    presc_hit  = (presc_q >= presc_term);
    tick       = (state_q == ST_RUN) && presc_hit && !cmd_wr;
    match      = (count == limit_q);
    cnt_load   = clear_cmd
               || (start_cmd && ((state_q == ST_IDLE) || (state_q == ST_DONE)))
               || (tick && match && ctrl_q.auto_reload);
    cnt_en     = tick && !match;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q  <= '0;
      limit_q <= '1;
      ctrl_q  <= '0;
    end else if (wr_pulse) begin
      case (addr)
        ADDR_LOAD:  load_q  <= data;
        ADDR_LIMIT: limit_q <= data;
        ADDR_CTRL:  ctrl_q  <= ctrl_t'(data);
        default:    ;
      endcase
    end
  end

  // Sequencing FSM with its prescaler and terminal-count pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      presc_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      tc_q <= tick && match;
      if (clear_cmd) begin
        state_q <= ST_IDLE;
        presc_q <= '0;
      end else if (stop_cmd) begin
        if (state_q == ST_RUN) begin
          state_q <= ST_PAUSED;
        end
      end else if (start_cmd && (state_q != ST_RUN)) begin
        state_q <= ST_RUN;
        presc_q <= '0;
      end else if (state_q == ST_RUN) begin
        presc_q <= presc_hit ? '0 : (presc_q + PRESCALE_W'(1));
        if (tick && match && !ctrl_q.auto_reload) begin
          state_q <= ST_DONE;
        end
      end
    end
  end

  counter_core u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (cnt_load),
    .load_val_i (load_q),
    .en_i       (cnt_en),
    .dir_i      (ctrl_q.dir),
    .count_o    (count)
  );

  assign uo_out  = {(state_q == ST_PAUSED), (state_q == ST_DONE), (state_q == ST_RUN), tc_q, count};
  assign uio_out = {limit_q, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule
